// File: rtl/dino_score_pkg.sv
// Shared constants and state encoding for the dino game BCD score engine.
package dino_score_pkg;

  localparam int                BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } state_e;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: synchronous clear, increment with 9->0 wrap and ripple carry out.
module bcd_digit
  import dino_score_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr,
  input  logic             inc_in,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc_in) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (ena) begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = inc_in & (q_q == BCD_MAX);

endmodule

// File: rtl/dino_score_counter.sv
// BCD score engine: run/over FSM, saturating score, session high score, multiplexed digit scan.
module dino_score_counter
  import dino_score_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    start,
  input  logic                    inc,
  input  logic                    game_over,
  input  logic                    show_hi,
  output logic [BCD_W*DIGITS-1:0] score_bcd,
  output logic [BCD_W*DIGITS-1:0] hiscore_bcd,
  output logic                    new_high,
  output logic                    saturated,
  output logic [1:0]              state,
  output logic [DIGITS-1:0]       dig_sel,
  output logic [BCD_W-1:0]        dig_bcd
);

  localparam int PRE_W = $clog2(SCAN_DIV + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e                    state_q, state_d;
  logic [BCD_W*DIGITS-1:0]   hiscore_q, hiscore_d;
  logic                      new_high_q, new_high_d;
  logic                      saturated_q, saturated_d;
  logic [PRE_W-1:0]          presc_q, presc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      clr_score, inc_eff;
  logic [DIGITS:0]           carry;
  logic [BCD_W*DIGITS-1:0]   scan_src;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    hiscore_d  = hiscore_q;
    new_high_d = 1'b0;
    clr_score  = 1'b0;
    inc_eff    = 1'b0;
    if (ena) begin
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_d   = S_RUN;
            clr_score = 1'b1;
          end
        end
        S_RUN: begin
          if (game_over) begin
            state_d = S_OVER;
            if (score_bcd > hiscore_q) begin
              hiscore_d  = score_bcd;
              new_high_d = 1'b1;
            end
          end else if (start) begin
            clr_score = 1'b1;
          end else if (inc) begin
            inc_eff = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A carry out of the top decade means the score is all nines: freeze digits, flag saturation.
  assign carry[0] = inc_eff;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena & ~carry[DIGITS]),
      .clr       (clr_score),
      .inc_in    (carry[g]),
      .q         (score_bcd[g*BCD_W +: BCD_W]),
      .carry_out (carry[g+1])
    );
  end

  always_comb begin
    saturated_d = saturated_q;
    if (clr_score) begin
      saturated_d = 1'b0;
    end else if (carry[DIGITS]) begin
      saturated_d = 1'b1;
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hiscore_q   <= '0;
      saturated_q <= 1'b0;
      presc_q     <= '0;
      idx_q       <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      hiscore_q   <= hiscore_d;
      saturated_q <= saturated_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
    end
  end

  // The pulse flop is not enable-gated so a stalled cycle always reads back as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_high_q <= 1'b0;
    end else begin
      new_high_q <= new_high_d;
    end
  end

  assign scan_src    = show_hi ? hiscore_q : score_bcd;
  assign dig_sel     = DIGITS'(1) << idx_q;
  assign dig_bcd     = scan_src[idx_q*BCD_W +: BCD_W];
  assign hiscore_bcd = hiscore_q;
  assign new_high    = new_high_q;
  assign saturated   = saturated_q;
  assign state       = state_q;

endmodule

// File: tb/tb_dino_score_counter.sv
// Randomized and directed bench for dino_score_counter against an integer-level game model.
module tb_dino_score_counter;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int MAX_SCORE = 9999;

  logic                clk = 1'b0;
  logic                rst_n, ena, start, inc, game_over, show_hi;
  logic [4*DIGITS-1:0] score_bcd, hiscore_bcd;
  logic                new_high, saturated;
  logic [1:0]          state;
  logic [DIGITS-1:0]   dig_sel;
  logic [3:0]          dig_bcd;

  int n_checks = 0;
  int n_errors = 0;

  // Model: plain integers for score/high score, scan position from a count of enabled cycles.
  int m_state, m_score, m_hi, m_cnt;
  bit m_sat, m_nh;

  dino_score_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start       (start),
    .inc         (inc),
    .game_over   (game_over),
    .show_hi     (show_hi),
    .score_bcd   (score_bcd),
    .hiscore_bcd (hiscore_bcd),
    .new_high    (new_high),
    .saturated   (saturated),
    .state       (state),
    .dig_sel     (dig_sel),
    .dig_bcd     (dig_bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_cnt = 0; m_sat = 0; m_nh = 0;
  endtask

  task automatic model_edge();
    m_nh = 0;
    if (ena) begin
      if (m_state == 1) begin
        if (game_over) begin
          m_state = 2;
          if (m_score > m_hi) begin
            m_hi = m_score;
            m_nh = 1;
          end
        end else if (start) begin
          m_score = 0;
          m_sat   = 0;
        end else if (inc) begin
          if (m_score == MAX_SCORE) m_sat = 1;
          else m_score++;
        end
      end else if (start) begin
        m_state = 1;
        m_score = 0;
        m_sat   = 0;
      end
      m_cnt++;
    end
  endtask

  task automatic compare_all();
    logic [15:0] src;
    int idx;
    idx = (m_cnt / SCAN_DIV) % DIGITS;
    src = show_hi ? to_bcd(m_hi) : to_bcd(m_score);
    check("state",     32'(state),       32'(m_state));
    check("score",     32'(score_bcd),   32'(to_bcd(m_score)));
    check("hiscore",   32'(hiscore_bcd), 32'(to_bcd(m_hi)));
    check("new_high",  32'(new_high),    32'(m_nh));
    check("saturated", 32'(saturated),   32'(m_sat));
    check("dig_sel",   32'(dig_sel),     32'(1) << idx);
    check("dig_bcd",   32'(dig_bcd),     32'(src[idx*4 +: 4]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit s, input bit i, input bit g);
    start = s; inc = i; game_over = g;
    step();
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) drive(0, 1, 0);
  endtask

  logic [3:0] scan_exp [4];
  logic [31:0] prev_sel;
  bit found;

  initial begin
    scan_exp = '{4'd4, 4'd3, 4'd2, 4'd1};
    rst_n = 1'b0; ena = 1'b1; start = 0; inc = 0; game_over = 0; show_hi = 0;
    model_reset();
    #12;
    compare_all();
    check("rst_dig_sel", 32'(dig_sel), 32'h1);
    rst_n = 1'b1;

    // Start then 12 points.
    drive(1, 0, 0);
    incs(12);
    check("score_12", 32'(score_bcd), 32'h0012);
    check("state_run", 32'(state), 32'h1);
    check("sat_12", 32'(saturated), 32'h0);

    // Multi-digit carry 0999 -> 1000.
    incs(999 - 12);
    check("score_0999", 32'(score_bcd), 32'h0999);
    incs(1);
    check("score_1000", 32'(score_bcd), 32'h1000);

    // Saturation and restart.
    incs(MAX_SCORE - 1000);
    check("score_9999", 32'(score_bcd), 32'h9999);
    incs(3);
    check("score_hold", 32'(score_bcd), 32'h9999);
    check("sat_set", 32'(saturated), 32'h1);
    drive(1, 0, 0);
    check("score_restart", 32'(score_bcd), 32'h0000);
    check("sat_clear", 32'(saturated), 32'h0);

    // High score: first game latches, equal second game does not.
    incs(42);
    drive(0, 0, 1);
    check("hi_42", 32'(hiscore_bcd), 32'h0042);
    check("nh_pulse", 32'(new_high), 32'h1);
    drive(0, 0, 0);
    check("nh_drop", 32'(new_high), 32'h0);
    drive(1, 0, 0);
    incs(42);
    drive(0, 0, 1);
    check("nh_equal", 32'(new_high), 32'h0);
    check("state_over", 32'(state), 32'h2);

    // game_over beats start and inc in RUN.
    drive(1, 0, 0);
    incs(7);
    drive(1, 1, 1);
    check("prio_state", 32'(state), 32'h2);
    check("prio_score", 32'(score_bcd), 32'h0007);
    drive(0, 1, 0);
    check("inc_over_ign", 32'(score_bcd), 32'h0007);

    // Clock enable low holds the score.
    drive(1, 0, 0);
    incs(3);
    ena = 1'b0;
    drive(0, 1, 0);
    drive(0, 1, 0);
    check("ena_hold", 32'(score_bcd), 32'h0003);
    ena = 1'b1;

    // Scan of 1234.
    drive(1, 0, 0);
    incs(1234);
    start = 0; inc = 0; game_over = 0;
    found = 0;
    prev_sel = 32'(dig_sel);
    for (int n = 0; n < 64 && !found; n++) begin
      step();
      if (dig_sel == 4'b0001 && prev_sel == 32'h8) found = 1;
      prev_sel = 32'(dig_sel);
    end
    check("scan_align", 32'(found), 32'h1);
    for (int k = 0; k < 16; k++) begin
      check("scan_sel", 32'(dig_sel), 32'(1) << (k / 4));
      check("scan_bcd", 32'(dig_bcd), 32'(scan_exp[k/4]));
      step();
    end
    check("scan_wrap", 32'(dig_sel), 32'h1);
    show_hi = 1'b1;
    #1;
    check("show_hi_bcd", 32'(dig_bcd), 32'(4'h2));
    show_hi = 1'b0;

    // Asynchronous reset mid-game.
    drive(1, 0, 0);
    incs(5);
    start = 0; inc = 0; game_over = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst_n = 1'b1;

    // Randomized play.
    for (int n = 0; n < 4000; n++) begin
      ena       = ($urandom_range(0, 7) != 0);
      start     = ($urandom_range(0, 39) == 0);
      game_over = ($urandom_range(0, 29) == 0);
      inc       = 1'($urandom_range(0, 1));
      show_hi   = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
